// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed common-anode seven-segment driver.
// Snapshots BCD once per frame, optional leading-zero blanking, dead-time scan.
module bcd_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_M1 = CW'(DEAD - 1);

    typedef enum logic {
        S_OFF,
        S_ON
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_idx;
    logic [15:0] r_sh_bcd;
    logic [3:0]  r_sh_dp;

    logic        w_snap;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg_dec;
    logic [3:0]  w_zero;
    logic [3:0]  w_lz;
    logic        w_blank;
    logic [6:0]  w_seg;
    logic [3:0]  w_an;
    logic        w_dp;

    assign w_snap = (r_cnt == '0) && (r_idx == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_sh_bcd <= 16'h0000;
            r_sh_dp  <= 4'h0;
        end else begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_snap) begin
                r_sh_bcd <= bcd;
                r_sh_dp  <= dp_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_OFF;
        else        r_state <= w_state_nxt;
    end

    // ON begins on the edge where cnt becomes DEAD and ends on the wrap.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_OFF: if (r_cnt == DEAD_M1) w_state_nxt = S_ON;
            S_ON:  if (r_cnt == LAST)    w_state_nxt = S_OFF;
        endcase
    end

    assign w_digit = r_sh_bcd[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg_dec = 7'h3F;
        case (w_digit)
            4'd0: w_seg_dec = 7'h40;
            4'd1: w_seg_dec = 7'h79;
            4'd2: w_seg_dec = 7'h24;
            4'd3: w_seg_dec = 7'h30;
            4'd4: w_seg_dec = 7'h19;
            4'd5: w_seg_dec = 7'h12;
            4'd6: w_seg_dec = 7'h02;
            4'd7: w_seg_dec = 7'h78;
            4'd8: w_seg_dec = 7'h00;
            4'd9: w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h3F;
        endcase
    end

    assign w_zero[0] = (r_sh_bcd[3:0]   == 4'd0);
    assign w_zero[1] = (r_sh_bcd[7:4]   == 4'd0);
    assign w_zero[2] = (r_sh_bcd[11:8]  == 4'd0);
    assign w_zero[3] = (r_sh_bcd[15:12] == 4'd0);

    // Digit 0 always shows, even when the whole value is zero.
    assign w_lz[3] = w_zero[3];
    assign w_lz[2] = w_zero[3] & w_zero[2];
    assign w_lz[1] = w_zero[3] & w_zero[2] & w_zero[1];
    assign w_lz[0] = 1'b0;

    assign w_blank = blank_lz & w_lz[r_idx];
    assign w_seg   = w_blank ? 7'h7F : w_seg_dec;
    assign w_an    = ~(4'b0001 << r_idx);
    assign w_dp    = ~r_sh_dp[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_snap;
            if (r_state == S_ON) begin
                an_n  <= w_an;
                seg_n <= w_seg;
                dp_n  <= w_dp;
            end else begin
                an_n  <= 4'hF;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule
